prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, program-memory word-address width (1024 x 16-bit words).
REQ-002 Parameter HDR, default 8'hA5, frame start byte.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  incoming byte from serial front end.
REQ-006 rx_valid  input  1  rx_data valid; byte consumed on a cycle with rx_valid && rx_ready.
REQ-007 rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 pm_we  output  1  program-memory write strobe, one cycle per word.
REQ-009 pm_addr  output  ADDR_W  program-memory word address.
REQ-010 pm_wdata  output  16  instruction word to write.
REQ-011 cpu_reset  output  1  held-reset to the microcontroller (microc + control unit).
REQ-012 load_done  output  1  last frame loaded and checksum good.
REQ-013 load_err  output  1  last frame rejected.

Function
REQ-014 Frame: HDR, LEN_HI, LEN_LO, then LEN words each as HI byte then LO byte, then one checksum byte.
REQ-015 FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR: a consumed byte equal to HDR -> LEN_HI, clears load_done/load_err, asserts cpu_reset, clears address counter and checksum; any other byte is consumed and ignored.
REQ-017 LEN_HI -> LEN_LO on a consumed byte; LEN_LO -> DATA_HI if 1 <= LEN <= 2**ADDR_W, else -> ERROR.
REQ-018 DATA_HI latches high byte -> DATA_LO; DATA_LO latches low byte -> WRITE.
REQ-019 WRITE lasts exactly one cycle: pm_we=1, pm_wdata={hi,lo}, pm_addr=current count; then count increments; -> CHECK if count reached LEN, else -> DATA_HI.
REQ-020 Address count starts at 0 and never wraps; the last word of a 1024-word frame is written at address 1023.
REQ-021 Checksum is the XOR of all data bytes (HI and LO); header and length bytes excluded.
REQ-022 CHECK: consumed byte equal to the checksum -> DONE, else -> ERROR.
REQ-023 DONE: load_done=1, cpu_reset=0. ERROR: load_err=1, cpu_reset=1.
REQ-024 rx_ready=1 in every state except WRITE; byte-to-write latency is 1 cycle after the LO byte is consumed.
REQ-025 pm_we=0 outside WRITE; pm_addr/pm_wdata hold their last values otherwise.
REQ-026 rx_valid low stalls the FSM in place with no state change; no timeout.
REQ-027 HDR appearing inside a frame is treated as data/length/checksum, not as a restart.
REQ-028 The CPU runs only in DONE: cpu_reset is asserted from the first HDR of any new frame until that frame completes successfully.

Reset
REQ-029 reset asserted at any time, including mid-frame, immediately forces IDLE, cpu_reset=1, pm_we=0, pm_addr=0, pm_wdata=0, load_done=0, load_err=0, rx_ready=1, count=0, checksum=0.
REQ-030 Program memory contents are not cleared by reset; a partially written frame stays in memory and the CPU stays held in reset.

Structure
REQ-031 State encodings, HDR and ADDR_W default belong in the shared package loader_pkg, which the testbench also uses.
REQ-032 Single module, no sub-modules; the program memory is external.

Verification
REQ-033 Frame A5 00 02 12 34 AB CD 40 -> writes 0x1234@0 and 0xABCD@1, load_done=1, cpu_reset falls after the checksum is consumed.
REQ-034 Same frame with checksum 41 -> both words written, load_err=1, load_done=0, cpu_reset stays 1.
REQ-035 LEN=0x0000, and separately LEN=0x0401 -> ERROR with no pm_we pulse; a following valid frame loads correctly.
REQ-036 Garbage bytes 00 FF 5A before A5 -> ignored; with rx_valid toggling every other cycle the frame still loads correctly; rx_ready=0 exactly during each WRITE cycle.
REQ-037 Assert reset after the first data word -> IDLE, all outputs at reset values; word 0 stays in memory.
REQ-038 1024-word frame -> last write at pm_addr=1023, load_done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: defaults, state encoding
// and the frame-length acceptance rule.
package loader_pkg;

  localparam int         LDR_ADDR_W = 10;
  localparam logic [7:0] LDR_HDR    = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHECK   = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8
  } ldr_state_e;

  // A frame must carry at least one word and no more than the memory holds.
  function automatic logic len_ok(input logic [15:0] len, input int aw);
    return (len != 16'd0) && (32'(len) <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses HDR/LEN/data/checksum frames, writes
// 16-bit words to external program memory and holds the CPU in reset until a good frame lands.
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = LDR_ADDR_W,
  parameter logic [7:0] HDR    = LDR_HDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              rx_ready_q, rx_ready_d;
  logic              pm_we_q, pm_we_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [15:0]       pm_wdata_q, pm_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              take_s;
  logic              last_word_s;

  assign take_s      = rx_valid && rx_ready_q;
  assign last_word_s = ((32'(count_q) + 32'd1) == 32'(len_q));

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    pm_addr_d   = pm_addr_q;
    pm_wdata_d  = pm_wdata_q;
    cpu_reset_d = cpu_reset_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (take_s && (rx_data == HDR)) begin
          state_d     = ST_LEN_HI;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          cpu_reset_d = 1'b1;
          count_d     = '0;
          csum_d      = 8'h00;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (take_s) begin
          len_d   = {rx_data, 8'h00};
          state_d = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (take_s) begin
          len_d = {len_q[15:8], rx_data};
          if (len_ok({len_q[15:8], rx_data}, ADDR_W)) begin
            state_d = ST_DATA_HI;
          end else begin
            state_d     = ST_ERROR;
            load_err_d  = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_HI: begin
        if (take_s) begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = ST_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_LO: begin
        // Word and address are staged here so they are registered exactly in WRITE.
        if (take_s) begin
          csum_d     = csum_q ^ rx_data;
          pm_wdata_d = {hi_q, rx_data};
          pm_addr_d  = count_q[ADDR_W-1:0];
          state_d    = ST_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        if (last_word_s) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DATA_HI;
        end
      end
      ST_CHECK: begin
        if (take_s) begin
          if (rx_data == csum_q) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = ST_ERROR;
            load_err_d  = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pm_we_d    = (state_d == ST_WRITE);
    rx_ready_d = (state_d != ST_WRITE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      len_q       <= 16'h0000;
      hi_q        <= 8'h00;
      csum_q      <= 8'h00;
      rx_ready_q  <= 1'b1;
      pm_we_q     <= 1'b0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= 16'h0000;
      cpu_reset_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      rx_ready_q  <= rx_ready_d;
      pm_we_q     <= pm_we_d;
      pm_addr_q   <= pm_addr_d;
      pm_wdata_q  <= pm_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign pm_we     = pm_we_q;
  assign pm_addr   = pm_addr_q;
  assign pm_wdata  = pm_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as frames are
// sent and matched against pm_we pulses; frame outcomes are checked after the checksum byte.
module tb_prog_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        pm_we;
  logic [9:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [25:0] exp_q[$];
  logic [15:0] data_w [0:1023];
  logic [15:0] mem    [0:1023];

  prog_loader #(.ADDR_W(LDR_ADDR_W), .HDR(LDR_HDR)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // External program memory model.
  always @(posedge clk) begin
    if (pm_we) mem[pm_addr] <= pm_wdata;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write scoreboard and ready/write exclusivity, sampled away from the active edge.
  always @(negedge clk) begin
    chk_val("ready_vs_write", {31'd0, rx_ready}, {31'd0, ~pm_we});
    if (pm_we) begin
      if (exp_q.size() == 0) begin
        chk_val("unexpected_write", {22'd0, pm_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk_val("wr_addr", {22'd0, pm_addr}, {22'd0, e[25:16]});
        chk_val("wr_data", {16'd0, pm_wdata}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waits;
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waits    = 0;
    while (!rx_ready && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!rx_ready) chk_val("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] csum_delta, input bit gap,
                            input bit expect_ok);
    logic [7:0]  cs;
    logic [15:0] w;
    cs = 8'h00;
    send_byte(LDR_HDR, gap);
    chk_val("hdr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk_val("hdr_done_clr", {31'd0, load_done}, 32'd0);
    chk_val("hdr_err_clr", {31'd0, load_err}, 32'd0);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    for (int i = 0; i < len; i++) begin
      w  = data_w[i];
      cs = cs ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], gap);
      exp_q.push_back({i[9:0], w});
      send_byte(w[7:0], gap);
      chk_val("write_latency", {31'd0, pm_we}, 32'd1);
    end
    send_byte(cs ^ csum_delta, gap);
    chk_val("frame_done", {31'd0, load_done}, {31'd0, expect_ok});
    chk_val("frame_err", {31'd0, load_err}, {31'd0, ~expect_ok});
    chk_val("frame_cpu_reset", {31'd0, cpu_reset}, {31'd0, ~expect_ok});
    chk_val("sb_drained", exp_q.size(), 32'd0);
  endtask

  task automatic bad_len(input logic [15:0] len);
    send_byte(LDR_HDR, 1'b0);
    send_byte(len[15:8], 1'b0);
    send_byte(len[7:0], 1'b0);
    chk_val("badlen_err", {31'd0, load_err}, 32'd1);
    chk_val("badlen_done", {31'd0, load_done}, 32'd0);
    chk_val("badlen_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk_val("badlen_no_write", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk_val({tag, "_ready"}, {31'd0, rx_ready}, 32'd1);
    chk_val({tag, "_we"}, {31'd0, pm_we}, 32'd0);
    chk_val({tag, "_addr"}, {22'd0, pm_addr}, 32'd0);
    chk_val({tag, "_wdata"}, {16'd0, pm_wdata}, 32'd0);
    chk_val({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    chk_val({tag, "_done"}, {31'd0, load_done}, 32'd0);
    chk_val({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    data_w[0] = 16'h1234;
    data_w[1] = 16'hABCD;
    #1;
    check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Garbage in IDLE is swallowed, then a frame with a stalling source.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    chk_val("garbage_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk_val("garbage_done", {31'd0, load_done}, 32'd0);
    send_frame(2, 8'h00, 1'b1, 1'b1);

    send_frame(2, 8'h00, 1'b0, 1'b1);
    send_frame(2, 8'h01, 1'b0, 1'b0);
    bad_len(16'h0000);
    send_frame(2, 8'h00, 1'b0, 1'b1);
    bad_len(16'h0401);
    send_frame(2, 8'h00, 1'b0, 1'b1);

    // Reset after the first data word has been written.
    send_byte(LDR_HDR, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    exp_q.push_back({10'd0, 16'h1234});
    send_byte(8'h34, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    chk_val("mem_kept", {16'd0, mem[0]}, 32'h0000_1234);
    @(posedge clk); #1;
    reset = 1'b0;
    send_frame(2, 8'h00, 1'b0, 1'b1);
    chk_val("mem0", {16'd0, mem[0]}, 32'h0000_1234);
    chk_val("mem1", {16'd0, mem[1]}, 32'h0000_ABCD);

    // Full-memory frame.
    for (int i = 0; i < 1024; i++) data_w[i] = 16'(i * 40503 + 7);
    send_frame(1024, 8'h00, 1'b0, 1'b1);
    chk_val("last_addr", {22'd0, pm_addr}, 32'd1023);
    chk_val("mem_last", {16'd0, mem[1023]}, {16'd0, data_w[1023]});

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
